// File: rtl/ascii_word_rx.sv
// ascii_word_rx: spots "Guatemala" and "Quetzal" in a valid-strobed
// ASCII stream; pulses, sticky last-word code and saturating tallies.
module ascii_word_rx #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             match_g,
   output logic             match_q,
   output logic [1:0]       word_id,
   output logic             busy,
   output logic [CNT_W-1:0] g_count,
   output logic [CNT_W-1:0] q_count
);

   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [3:0] G_LAST = 4'd8;
   localparam logic [2:0] Q_LAST = 3'd6;

   function automatic logic [7:0] g_chr(input logic [3:0] i);
      case (i)
         4'd0:    g_chr = 8'h47;
         4'd1:    g_chr = 8'h75;
         4'd2:    g_chr = 8'h61;
         4'd3:    g_chr = 8'h74;
         4'd4:    g_chr = 8'h65;
         4'd5:    g_chr = 8'h6D;
         4'd6:    g_chr = 8'h61;
         4'd7:    g_chr = 8'h6C;
         4'd8:    g_chr = 8'h61;
         default: g_chr = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] q_chr(input logic [2:0] i);
      case (i)
         3'd0:    q_chr = 8'h51;
         3'd1:    q_chr = 8'h75;
         3'd2:    q_chr = 8'h65;
         3'd3:    q_chr = 8'h74;
         3'd4:    q_chr = 8'h7A;
         3'd5:    q_chr = 8'h61;
         3'd6:    q_chr = 8'h6C;
         default: q_chr = 8'h00;
      endcase
   endfunction

   logic [3:0]    gi, gi_nx;
   logic [2:0]    qi, qi_nx;
   logic [IW-1:0] idle, idle_nx;
   logic          g_done, q_done;
   logic          g_hit, g_end, q_hit, q_end;

   assign g_hit = (char_in == g_chr(gi));
   assign g_end = (gi == G_LAST);
   assign q_hit = (char_in == q_chr(qi));
   assign q_end = (qi == Q_LAST);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         gi      <= '0;
         qi      <= '0;
         idle    <= '0;
         match_g <= 1'b0;
         match_q <= 1'b0;
         word_id <= 2'b00;
         g_count <= '0;
         q_count <= '0;
      end else begin
         gi      <= gi_nx;
         qi      <= qi_nx;
         idle    <= idle_nx;
         match_g <= g_done;
         match_q <= q_done;
         if (g_done)
            word_id <= 2'b01;
         else if (q_done)
            word_id <= 2'b10;
         if (g_done && g_count != '1)
            g_count <= g_count + CNT_W'(1);
         if (q_done && q_count != '1)
            q_count <= q_count + CNT_W'(1);
      end
   end

   // First letters are unique in each word, so a mismatch on them
   // restarts at index 1 without any longer-prefix fallback.
   always_comb begin
      gi_nx   = gi;
      qi_nx   = qi;
      idle_nx = idle;
      g_done  = 1'b0;
      q_done  = 1'b0;
      if (char_valid) begin
         idle_nx = '0;
         unique case (1'b1)
            g_hit && g_end: begin
               gi_nx  = '0;
               g_done = 1'b1;
            end
            g_hit && !g_end:          gi_nx = gi + 4'd1;
            !g_hit && char_in == 8'h47: gi_nx = 4'd1;
            default:                  gi_nx = '0;
         endcase
         unique case (1'b1)
            q_hit && q_end: begin
               qi_nx  = '0;
               q_done = 1'b1;
            end
            q_hit && !q_end:          qi_nx = qi + 3'd1;
            !q_hit && char_in == 8'h51: qi_nx = 3'd1;
            default:                  qi_nx = '0;
         endcase
      end else if (TIMEOUT > 0) begin
         if (idle != IW'(TIMEOUT))
            idle_nx = idle + IW'(1);
         if (idle_nx == IW'(TIMEOUT)) begin
            gi_nx = '0;
            qi_nx = '0;
         end
      end
   end

   always_comb begin
      busy = (gi != '0) || (qi != '0);
   end

endmodule

// File: tb/tb_ascii_word_rx.sv
// Bench for ascii_word_rx: vector table, corner sequences and random
// stream against a history-based word model, on two parameter sets.
module tb_ascii_word_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;

   logic       mg_a, mq_a, busy_a;
   logic [1:0] wid_a;
   logic [7:0] gc_a, qc_a;
   logic       mg_b, mq_b, busy_b;
   logic [1:0] wid_b;
   logic [1:0] gc_b, qc_b;

   always #5 clk = ~clk;

   ascii_word_rx dut_a (
      .clk(clk), .rst_n(rst_n), .char_in(char_in),
      .char_valid(char_valid), .match_g(mg_a), .match_q(mq_a),
      .word_id(wid_a), .busy(busy_a), .g_count(gc_a), .q_count(qc_a)
   );

   ascii_word_rx #(.TIMEOUT(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .char_in(char_in),
      .char_valid(char_valid), .match_g(mg_b), .match_q(mq_b),
      .word_id(wid_b), .busy(busy_b), .g_count(gc_b), .q_count(qc_b)
   );

   int total = 0;
   int bad = 0;
   int pg_a, pq_a, pg_b, pq_b;

   // Reference: remembers the valid chars since the last clear and
   // decides matches/busy from suffixes of that history.
   byte unsigned hist[2][16];
   int  hlen[2];
   int  idle[2];
   int  gcnt[2];
   int  qcnt[2];
   bit  m_g[2];
   bit  m_q[2];
   int  m_wid[2];
   int  tmo[2]  = '{255, 4};
   int  cmax[2] = '{255, 3};

   function automatic bit ends_with(input int id, input string w);
      int n = w.len();
      if (hlen[id] < n) return 1'b0;
      for (int i = 0; i < n; i++)
         if (hist[id][hlen[id]-n+i] != w[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit open_prefix(input int id, input string w);
      for (int k = 1; k < w.len(); k++) begin
         bit ok = (hlen[id] >= k);
         for (int j = 0; j < k && ok; j++)
            if (hist[id][hlen[id]-k+j] != w[j]) ok = 1'b0;
         if (ok) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void mstep(input int id, input bit r, input bit v,
                                 input byte unsigned c);
      if (r) begin
         hlen[id] = 0; idle[id] = 0; m_g[id] = 0; m_q[id] = 0;
         m_wid[id] = 0; gcnt[id] = 0; qcnt[id] = 0;
      end else if (v) begin
         idle[id] = 0;
         if (hlen[id] == 16) begin
            for (int i = 0; i < 15; i++) hist[id][i] = hist[id][i+1];
            hlen[id] = 15;
         end
         hist[id][hlen[id]] = c;
         hlen[id]++;
         m_g[id] = ends_with(id, "Guatemala");
         m_q[id] = ends_with(id, "Quetzal");
         if (m_g[id]) begin
            m_wid[id] = 1;
            if (gcnt[id] < cmax[id]) gcnt[id]++;
         end
         if (m_q[id]) begin
            m_wid[id] = 2;
            if (qcnt[id] < cmax[id]) qcnt[id]++;
         end
      end else begin
         m_g[id] = 0; m_q[id] = 0;
         idle[id]++;
         if (tmo[id] > 0 && idle[id] >= tmo[id]) hlen[id] = 0;
      end
   endfunction

   function automatic bit m_busy(input int id);
      return open_prefix(id, "Guatemala") || open_prefix(id, "Quetzal");
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit v, input logic [7:0] c);
      rst_n = r; char_valid = v; char_in = c;
      @(posedge clk);
      mstep(0, r, v, c);
      mstep(1, r, v, c);
      #1;
      chk("a_match_g", mg_a, m_g[0]);
      chk("a_match_q", mq_a, m_q[0]);
      chk("a_word_id", wid_a, m_wid[0]);
      chk("a_busy", busy_a, m_busy(0));
      chk("a_g_count", gc_a, gcnt[0]);
      chk("a_q_count", qc_a, qcnt[0]);
      chk("b_match_g", mg_b, m_g[1]);
      chk("b_match_q", mq_b, m_q[1]);
      chk("b_word_id", wid_b, m_wid[1]);
      chk("b_busy", busy_b, m_busy(1));
      chk("b_g_count", gc_b, gcnt[1]);
      chk("b_q_count", qc_b, qcnt[1]);
      pg_a += int'(mg_a); pq_a += int'(mq_a);
      pg_b += int'(mg_b); pq_b += int'(mq_b);
   endtask

   task automatic send(input string w, input int gap);
      for (int i = 0; i < w.len(); i++) begin
         cyc(1'b0, 1'b1, w[i]);
         for (int k = 0; k < gap; k++) cyc(1'b0, 1'b0, 8'($urandom));
      end
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 8'h00);
      pg_a = 0; pq_a = 0; pg_b = 0; pq_b = 0;
   endtask

   typedef struct packed {
      logic       rst;
      logic       vld;
      logic [7:0] ch;
      logic       mg;
      logic       mq;
      logic [1:0] wid;
      logic       busy;
      logic [7:0] gc;
   } vec_t;

   vec_t tbl[10];

   initial begin
      string alpha;
      tbl[0] = '{1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[1] = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[2] = '{1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[3] = '{1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[4] = '{1'b0, 1'b1, 8'h65, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[5] = '{1'b0, 1'b1, 8'h6D, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[6] = '{1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[7] = '{1'b0, 1'b1, 8'h6C, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0};
      tbl[8] = '{1'b0, 1'b1, 8'h61, 1'b1, 1'b0, 2'd1, 1'b0, 8'd1};
      tbl[9] = '{1'b0, 1'b0, 8'h47, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
      alpha = "GuatemalQz";
      pg_a = 0; pq_a = 0; pg_b = 0; pq_b = 0;

      // reset with random inputs
      cyc(1'b1, 1'($urandom), 8'($urandom));
      cyc(1'b1, 1'($urandom), 8'($urandom));
      chk("rst_word_id", wid_a, 0);
      chk("rst_counts", int'(gc_a) + int'(qc_a) + int'(gc_b), 0);
      chk("rst_busy", busy_a | busy_b, 0);
      chk("rst_match", mg_a | mq_a | mg_b | mq_b, 0);

      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].rst, tbl[i].vld, tbl[i].ch);
         chk("tbl_match_g", mg_a, tbl[i].mg);
         chk("tbl_match_q", mq_a, tbl[i].mq);
         chk("tbl_word_id", wid_a, tbl[i].wid);
         chk("tbl_busy", busy_a, tbl[i].busy);
         chk("tbl_g_count", gc_a, tbl[i].gc);
      end

      // Quetzal spread by 3 idle cycles
      do_reset();
      send("Quetzal", 3);
      chk("gap_q_pulses", pq_a, 1);
      chk("gap_word_id", wid_a, 2);
      chk("gap_q_count", qc_a, 1);
      chk("gap_b_q_count", qc_b, 1);

      // restart inside a partial word
      do_reset();
      begin
         string s = "GuaGuatemala";
         for (int i = 0; i < s.len(); i++) begin
            cyc(1'b0, 1'b1, s[i]);
            chk("restart_busy", busy_a, (i < s.len() - 1) ? 1 : 0);
         end
      end
      chk("restart_g_pulses", pg_a, 1);
      chk("restart_g_count", gc_a, 1);

      // timeout drops partial match on the TIMEOUT=4 instance only
      do_reset();
      send("Guat", 0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h00);
      chk("tmo_b_busy", busy_b, 0);
      chk("tmo_a_busy", busy_a, 1);
      send("emala", 0);
      chk("tmo_b_g_pulses", pg_b, 0);
      chk("tmo_a_g_pulses", pg_a, 1);

      // saturation, then reset in the middle of a word
      do_reset();
      for (int n = 0; n < 5; n++) send("Quetzal", 0);
      chk("sat_b_q_pulses", pq_b, 5);
      chk("sat_b_q_count", qc_b, 3);
      chk("sat_a_q_count", qc_a, 5);
      send("Qu", 0);
      cyc(1'b1, 1'b1, 8'h65);
      send("tzal", 0);
      chk("midrst_b_q_pulses", pq_b, 5);
      chk("midrst_b_q_count", qc_b, 0);
      chk("midrst_b_word_id", wid_b, 0);

      // random stream
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r = $urandom_range(0, 99);
         if ($urandom_range(0, 299) == 0)
            cyc(1'b1, 1'($urandom), 8'($urandom));
         else if (r < 3)
            send(($urandom & 1) ? "Guatemala" : "Quetzal", 0);
         else if (r < 6)
            for (int k = 0; k < $urandom_range(3, 6); k++)
               cyc(1'b0, 1'b0, 8'($urandom));
         else if (r < 20)
            cyc(1'b0, 1'b0, 8'($urandom));
         else if (r < 30)
            cyc(1'b0, 1'b1, 8'($urandom));
         else
            cyc(1'b0, 1'b1, alpha[$urandom_range(0, 9)]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
